// File: rtl/cpu_defs.sv
// Shared definitions for the bus-based CPU control path: opcodes, IR field
// positions, sequencer states and instruction classes.
package cpu_defs;

  localparam int OPW_DEFAULT = 5;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD      = 5'b00011;
  localparam logic [4:0] OP_SUB      = 5'b00100;
  localparam logic [4:0] OP_AND      = 5'b00101;
  localparam logic [4:0] OP_OR       = 5'b00110;
  localparam logic [4:0] OP_ALU_LAST = 5'b01011;
  localparam logic [4:0] OP_ADDI     = 5'b01100;
  localparam logic [4:0] OP_ANDI     = 5'b01101;
  localparam logic [4:0] OP_ORI      = 5'b01110;
  localparam logic [4:0] OP_MUL      = 5'b01111;
  localparam logic [4:0] OP_DIV      = 5'b10000;
  localparam logic [4:0] OP_NEG      = 5'b10001;
  localparam logic [4:0] OP_NOT      = 5'b10010;
  localparam logic [4:0] OP_NOP      = 5'b11010;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU3,
    C_IMM,
    C_MULDIV,
    C_UNARY,
    C_NOP,
    C_HALT
  } op_class_t;

endpackage

// File: rtl/op_decode.sv
// Classifies a latched opcode and produces the ALU operation it drives.
// Undefined opcodes fall into the NOP class.
module op_decode
  import cpu_defs::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class,
  output logic [OPW-1:0] alu_op
);

  always_comb begin
    op_class = C_NOP;
    alu_op   = '0;
    if (opcode >= OPW'(OP_ADD) && opcode <= OPW'(OP_ALU_LAST)) begin
      op_class = C_ALU3;
      alu_op   = opcode;
    end else begin
      case (opcode)
        OPW'(OP_ADDI): begin
          op_class = C_IMM;
          alu_op   = OPW'(OP_ADD);
        end
        OPW'(OP_ANDI): begin
          op_class = C_IMM;
          alu_op   = OPW'(OP_AND);
        end
        OPW'(OP_ORI): begin
          op_class = C_IMM;
          alu_op   = OPW'(OP_OR);
        end
        OPW'(OP_MUL), OPW'(OP_DIV): begin
          op_class = C_MULDIV;
          alu_op   = opcode;
        end
        OPW'(OP_NEG), OPW'(OP_NOT): begin
          op_class = C_UNARY;
          alu_op   = opcode;
        end
        OPW'(OP_HALT): op_class = C_HALT;
        default:       op_class = C_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the bus CPU. Moore outputs decoded from
// the state register and the opcode captured at the end of fetch.
//
// state   | meaning
// RESET   | held while clear is high, all outputs 0
// T0..T2  | fetch: PC to MAR, memory read into MDR, MDR to IR
// T3..T6  | execute, length depends on the opcode class
// HALT    | stopped until clear, run=0
module control_sequencer
  import cpu_defs::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [31:0]    IR,
  output logic           PCout,
  output logic           ZLOout,
  output logic           ZHIout,
  output logic           MDRout,
  output logic           Cout,
  output logic           PCin,
  output logic           MARin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           Zlowin,
  output logic           Zhighin,
  output logic           LOin,
  output logic           HIin,
  output logic           IncPC,
  output logic           read,
  output logic [OPW-1:0] operation,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           run
);

  state_t          state, state_nxt;
  logic [OPW-1:0]  opcode_q;
  op_class_t       op_class;
  logic [OPW-1:0]  alu_op;
  logic            unused_ir;

  // Register fields are consumed by the select/encode logic, not here.
  assign unused_ir = ^IR[OP_LSB-1:0];

  op_decode #(.OPW(OPW)) u_op_decode (
    .opcode   (opcode_q),
    .op_class (op_class),
    .alu_op   (alu_op)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= S_RESET;
      opcode_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_T2) opcode_q <= OPW'(IR[OP_MSB:OP_LSB]);
    end
  end

  always_comb begin
    state_nxt = state;
    PCout     = 1'b0;
    ZLOout    = 1'b0;
    ZHIout    = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    LOin      = 1'b0;
    HIin      = 1'b0;
    IncPC     = 1'b0;
    read      = 1'b0;
    operation = '0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    run       = (state != S_RESET) && (state != S_HALT);

    case (state)
      S_RESET: state_nxt = S_T0;
      S_T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        Zlowin    = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        ZLOout    = 1'b1;
        PCin      = 1'b1;
        read      = 1'b1;
        MDRin     = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        state_nxt = S_T4;
        case (op_class)
          C_ALU3, C_IMM: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          C_MULDIV: begin
            Gra  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          C_UNARY: begin
            Grb       = 1'b1;
            Rout      = 1'b1;
            operation = alu_op;
            Zlowin    = 1'b1;
          end
          C_HALT:  state_nxt = S_HALT;
          default: state_nxt = S_T0;
        endcase
      end
      S_T4: begin
        state_nxt = S_T5;
        case (op_class)
          C_ALU3: begin
            Grc       = 1'b1;
            Rout      = 1'b1;
            operation = alu_op;
            Zlowin    = 1'b1;
          end
          C_IMM: begin
            Cout      = 1'b1;
            operation = alu_op;
            Zlowin    = 1'b1;
          end
          C_MULDIV: begin
            Grb       = 1'b1;
            Rout      = 1'b1;
            operation = alu_op;
            Zlowin    = 1'b1;
            Zhighin   = 1'b1;
          end
          C_UNARY: begin
            ZLOout    = 1'b1;
            Gra       = 1'b1;
            Rin       = 1'b1;
            state_nxt = S_T0;
          end
          default: state_nxt = S_T0;
        endcase
      end
      S_T5: begin
        state_nxt = S_T0;
        ZLOout    = 1'b1;
        if (op_class == C_MULDIV) begin
          LOin      = 1'b1;
          state_nxt = S_T6;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        ZHIout    = 1'b1;
        HIin      = 1'b1;
        state_nxt = S_T0;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table of instructions with a per-cycle
// scoreboard of expected control words, plus halt and mid-fetch clear cases.
module tb_control_sequencer;
  import cpu_defs::*;

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out, c_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, lo_in, hi_in;
    logic inc_pc, rd, gra, grb, grc, r_in, r_out, run;
    logic [4:0] op;
  } ctl_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          cpi;
  } vec_t;

  logic        clock, clear;
  logic [31:0] IR;
  logic PCout, ZLOout, ZHIout, MDRout, Cout, PCin, MARin, MDRin, IRin, Yin;
  logic Zlowin, Zhighin, LOin, HIin, IncPC, read, Gra, Grb, Grc, Rin, Rout, run;
  logic [4:0] operation;
  ctl_t act_w;

  int checks = 0;
  int failures = 0;
  ctl_t sb[$];

  control_sequencer #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .IR(IR),
    .PCout(PCout), .ZLOout(ZLOout), .ZHIout(ZHIout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .LOin(LOin), .HIin(HIin),
    .IncPC(IncPC), .read(read), .operation(operation),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .run(run)
  );

  assign act_w = {PCout, ZLOout, ZHIout, MDRout, Cout,
                  PCin, MARin, MDRin, IRin, Yin, Zlowin, Zhighin, LOin, HIin,
                  IncPC, read, Gra, Grb, Grc, Rin, Rout, run, operation};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Expected control words for one instruction, straight from the state tables.
  task automatic push_instr(input logic [4:0] op);
    ctl_t t;
    t = '0; t.run = 1; t.pc_out = 1; t.mar_in = 1; t.inc_pc = 1; t.zlo_in = 1; sb.push_back(t);
    t = '0; t.run = 1; t.zlo_out = 1; t.pc_in = 1; t.rd = 1; t.mdr_in = 1; sb.push_back(t);
    t = '0; t.run = 1; t.mdr_out = 1; t.ir_in = 1; sb.push_back(t);
    if (op >= 5'b00011 && op <= 5'b01011) begin
      t = '0; t.run = 1; t.grb = 1; t.r_out = 1; t.y_in = 1; sb.push_back(t);
      t = '0; t.run = 1; t.grc = 1; t.r_out = 1; t.op = op; t.zlo_in = 1; sb.push_back(t);
      t = '0; t.run = 1; t.zlo_out = 1; t.gra = 1; t.r_in = 1; sb.push_back(t);
    end else if (op == 5'b01100 || op == 5'b01101 || op == 5'b01110) begin
      t = '0; t.run = 1; t.grb = 1; t.r_out = 1; t.y_in = 1; sb.push_back(t);
      t = '0; t.run = 1; t.c_out = 1; t.zlo_in = 1;
      t.op = (op == 5'b01100) ? 5'b00011 : (op == 5'b01101) ? 5'b00101 : 5'b00110;
      sb.push_back(t);
      t = '0; t.run = 1; t.zlo_out = 1; t.gra = 1; t.r_in = 1; sb.push_back(t);
    end else if (op == 5'b01111 || op == 5'b10000) begin
      t = '0; t.run = 1; t.gra = 1; t.r_out = 1; t.y_in = 1; sb.push_back(t);
      t = '0; t.run = 1; t.grb = 1; t.r_out = 1; t.op = op; t.zlo_in = 1; t.zhi_in = 1; sb.push_back(t);
      t = '0; t.run = 1; t.zlo_out = 1; t.lo_in = 1; sb.push_back(t);
      t = '0; t.run = 1; t.zhi_out = 1; t.hi_in = 1; sb.push_back(t);
    end else if (op == 5'b10001 || op == 5'b10010) begin
      t = '0; t.run = 1; t.grb = 1; t.r_out = 1; t.op = op; t.zlo_in = 1; sb.push_back(t);
      t = '0; t.run = 1; t.zlo_out = 1; t.gra = 1; t.r_in = 1; sb.push_back(t);
    end else begin
      t = '0; t.run = 1; sb.push_back(t);
    end
  endtask

  task automatic check_cycle(input string tag);
    ctl_t act, exp;
    act = act_w;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, actual=%h", tag, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: actual=%h required=%h", tag, act, exp);
      end
    end
    checks++;
    if ($countones({act.pc_out, act.zlo_out, act.zhi_out, act.mdr_out, act.c_out}) > 1) begin
      failures++;
      $display("FAIL %s bus_sources: actual=%b required=at most one set", tag,
               {act.pc_out, act.zlo_out, act.zhi_out, act.mdr_out, act.c_out});
    end
  endtask

  // IR for the following instruction is changed during T3, after the opcode is latched.
  task automatic run_instr(input string tag, input logic [31:0] ir_now, input int cpi,
                           input logic [31:0] ir_next);
    push_instr(ir_now[31:27]);
    for (int c = 0; c < cpi; c++) begin
      @(negedge clock);
      check_cycle($sformatf("%s_c%0d", tag, c));
      if (c == 3) IR = ir_next;
    end
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{"mul",   32'h7b380000, 7};
    tbl[1]  = '{"add",   32'h19100000, 6};
    tbl[2]  = '{"addi",  32'h61000000, 6};
    tbl[3]  = '{"sub",   32'h20000000, 6};
    tbl[4]  = '{"and",   32'h28000000, 6};
    tbl[5]  = '{"alu11", 32'h58000000, 6};
    tbl[6]  = '{"andi",  32'h68000000, 6};
    tbl[7]  = '{"ori",   32'h70000000, 6};
    tbl[8]  = '{"div",   32'h80000000, 7};
    tbl[9]  = '{"neg",   32'h88000000, 5};
    tbl[10] = '{"not",   32'h90000000, 5};
    tbl[11] = '{"nop",   32'hD0000000, 4};
    tbl[12] = '{"undef", 32'hF8000000, 4};

    clear = 1'b1;
    IR    = tbl[0].ir;
    @(negedge clock);
    sb.push_back('0);
    check_cycle("reset");
    clear = 1'b0;

    for (int i = 0; i < 13; i++)
      run_instr(tbl[i].name, tbl[i].ir, tbl[i].cpi, (i < 12) ? tbl[i+1].ir : 32'hD8000000);

    run_instr("halt", 32'hD8000000, 4, 32'hD8000000);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      sb.push_back('0);
      check_cycle($sformatf("halted_%0d", k));
    end

    #2 clear = 1'b1;
    IR = 32'hD0000000;
    #1 sb.push_back('0);
    check_cycle("halt_clear");
    #1 clear = 1'b0;
    run_instr("after_halt_nop", 32'hD0000000, 4, 32'h7b380000);

    push_instr(5'b01111);
    @(negedge clock);
    check_cycle("mulclr_t0");
    @(negedge clock);
    check_cycle("mulclr_t1");
    sb.delete();
    #2 clear = 1'b1;
    #1 sb.push_back('0);
    check_cycle("clear_mid_t1");
    #1 clear = 1'b0;
    run_instr("mul_after_clear", 32'h7b380000, 7, 32'hD0000000);
    run_instr("final_nop", 32'hD0000000, 4, 32'hD0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
